segre_dcache_ctrl: RTL and testbench



---
 rtl/segre_dcache_ctrl.sv | 157 +++++++++++++++
 tb/tb_segre_dcache_ctrl.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/segre_dcache_ctrl.sv
// Sequencing controller for the fully associative data-cache tag array:
// lookup, miss line-fill with round-robin victim, replay, and invalidate-all.
module segre_dcache_ctrl #(
    parameter int ADDR_WIDTH = 32,
    parameter int BYTE_SIZE  = 4,
    parameter int NUM_LANES  = 8,
    parameter int INDEX_SIZE = $clog2(NUM_LANES),
    parameter int TAG_SIZE   = ADDR_WIDTH - BYTE_SIZE
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  core_req_i,
    input  logic [ADDR_WIDTH-1:0] core_addr_i,
    output logic                  core_ready_o,
    output logic                  core_valid_o,
    output logic                  core_hit_o,
    output logic [INDEX_SIZE-1:0] core_lane_o,
    input  logic                  inv_req_i,
    output logic                  inv_ack_o,
    output logic                  tag_req_o,
    output logic [TAG_SIZE-1:0]   tag_tag_o,
    output logic [INDEX_SIZE-1:0] tag_index_o,
    output logic                  tag_fill_o,
    output logic                  tag_invalidate_o,
    input  logic                  tag_hit_i,
    input  logic                  tag_miss_i,
    input  logic [INDEX_SIZE-1:0] tag_lane_i,
    output logic                  mem_rd_req_o,
    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    input  logic                  mem_ack_i,
    output logic                  busy_o
);

    typedef enum logic [2:0] {
        IDLE,
        LOOKUP,
        MISS_REQ,
        FILL,
        RESP,
        INV
    } state_t;

    state_t                state_q, state_d;
    logic [TAG_SIZE-1:0]   tag_q;
    logic                  first_miss_q;
    logic [INDEX_SIZE-1:0] lane_q;
    logic [INDEX_SIZE-1:0] victim_q;

    // Byte offset within a line never reaches the tag array or memory.
    logic unused_offset;
    assign unused_offset = ^core_addr_i[BYTE_SIZE-1:0];

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q      <= IDLE;
            tag_q        <= '0;
            first_miss_q <= 1'b0;
            lane_q       <= '0;
            victim_q     <= '0;
        end else begin
            state_q <= state_d;
            case (state_q)
                IDLE: begin
                    if (!inv_req_i && core_req_i) begin
                        tag_q        <= core_addr_i[ADDR_WIDTH-1:BYTE_SIZE];
                        first_miss_q <= 1'b0;
                    end
                end
                LOOKUP: begin
                    if (tag_hit_i) begin
                        lane_q <= tag_lane_i;
                    end else if (tag_miss_i) begin
                        first_miss_q <= 1'b1;
                    end
                end
                FILL: begin
                    // Explicit wrap keeps round-robin correct for non power-of-two lane counts.
                    if (victim_q == INDEX_SIZE'(NUM_LANES - 1)) begin
                        victim_q <= '0;
                    end else begin
                        victim_q <= victim_q + 1'b1;
                    end
                end
                INV: begin
                    victim_q <= '0;
                end
                default: begin
                end
            endcase
        end
    end

    always_comb begin
        state_d          = state_q;
        core_ready_o     = 1'b0;
        core_valid_o     = 1'b0;
        core_hit_o       = 1'b0;
        core_lane_o      = '0;
        inv_ack_o        = 1'b0;
        tag_req_o        = 1'b0;
        tag_tag_o        = '0;
        tag_index_o      = '0;
        tag_fill_o       = 1'b0;
        tag_invalidate_o = 1'b0;
        mem_rd_req_o     = 1'b0;
        mem_addr_o       = '0;
        case (state_q)
            IDLE: begin
                core_ready_o = !inv_req_i;
                if (inv_req_i) begin
                    state_d = INV;
                end else if (core_req_i) begin
                    state_d = LOOKUP;
                end
            end
            LOOKUP: begin
                tag_req_o = 1'b1;
                tag_tag_o = tag_q;
                if (tag_hit_i) begin
                    state_d = RESP;
                end else if (tag_miss_i) begin
                    state_d = MISS_REQ;
                end
            end
            MISS_REQ: begin
                mem_rd_req_o = 1'b1;
                mem_addr_o   = {tag_q, {BYTE_SIZE{1'b0}}};
                if (mem_ack_i) begin
                    state_d = FILL;
                end
            end
            FILL: begin
                tag_fill_o  = 1'b1;
                tag_tag_o   = tag_q;
                tag_index_o = victim_q;
                state_d     = LOOKUP;
            end
            RESP: begin
                core_valid_o = 1'b1;
                core_hit_o   = !first_miss_q;
                core_lane_o  = lane_q;
                state_d      = IDLE;
            end
            INV: begin
                tag_invalidate_o = 1'b1;
                inv_ack_o        = 1'b1;
                state_d          = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign busy_o = (state_q != IDLE);

endmodule

// File: tb/tb_segre_dcache_ctrl.sv
// Self-checking bench for segre_dcache_ctrl: a behavioural tag-array model,
// table-driven lookup/fill vectors and hand-written invalidate/reset sequences.
module tb_segre_dcache_ctrl;

    logic        clk;
    logic        rst;
    logic        core_req;
    logic [31:0] core_addr;
    logic        core_ready_o;
    logic        core_valid_o;
    logic        core_hit_o;
    logic [2:0]  core_lane_o;
    logic        inv_req;
    logic        inv_ack_o;
    logic        tag_req_o;
    logic [27:0] tag_tag_o;
    logic [2:0]  tag_index_o;
    logic        tag_fill_o;
    logic        tag_invalidate_o;
    logic        tag_hit;
    logic        tag_miss;
    logic [2:0]  tag_lane;
    logic        mem_rd_req_o;
    logic [31:0] mem_addr_o;
    logic        mem_ack;
    logic        busy_o;

    int assertCount = 0;
    int failCount   = 0;

    segre_dcache_ctrl dut (
        .clk_i            (clk),
        .rst_i            (rst),
        .core_req_i       (core_req),
        .core_addr_i      (core_addr),
        .core_ready_o     (core_ready_o),
        .core_valid_o     (core_valid_o),
        .core_hit_o       (core_hit_o),
        .core_lane_o      (core_lane_o),
        .inv_req_i        (inv_req),
        .inv_ack_o        (inv_ack_o),
        .tag_req_o        (tag_req_o),
        .tag_tag_o        (tag_tag_o),
        .tag_index_o      (tag_index_o),
        .tag_fill_o       (tag_fill_o),
        .tag_invalidate_o (tag_invalidate_o),
        .tag_hit_i        (tag_hit),
        .tag_miss_i       (tag_miss),
        .tag_lane_i       (tag_lane),
        .mem_rd_req_o     (mem_rd_req_o),
        .mem_addr_o       (mem_addr_o),
        .mem_ack_i        (mem_ack),
        .busy_o           (busy_o)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Behavioural fully associative tag array answering the controller.
    logic        modelValid [8];
    logic [27:0] modelTag   [8];

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 8; i++) modelValid[i] <= 1'b0;
        end else if (tag_invalidate_o) begin
            for (int i = 0; i < 8; i++) modelValid[i] <= 1'b0;
        end else if (tag_fill_o) begin
            modelValid[tag_index_o] <= 1'b1;
            modelTag[tag_index_o]   <= tag_tag_o;
        end
    end

    always_comb begin
        tag_hit  = 1'b0;
        tag_miss = 1'b0;
        tag_lane = 3'd0;
        if (tag_req_o) begin
            tag_miss = 1'b1;
            for (int i = 0; i < 8; i++) begin
                if (modelValid[i] && modelTag[i] == tag_tag_o) begin
                    tag_hit  = 1'b1;
                    tag_miss = 1'b0;
                    tag_lane = 3'(i);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached, actual running required finished");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input longint actual, input longint expected);
        assertCount++;
        if (actual != expected) begin
            failCount++;
            $display("[TB] FAIL %s: actual %0h required %0h", name, actual, expected);
        end
    endtask

    // Issues one core request from IDLE and follows it to the response.
    task automatic applyStimulus(
        input  logic [31:0] addr,
        input  int          ackN,
        output bit          hit,
        output int          lane,
        output bit          memSeen,
        output logic [31:0] memAddr,
        output int          fillLane,
        output logic [27:0] fillTag,
        output int          latency
    );
        int reqCount;
        int cyc;
        hit = 0; lane = -1; memSeen = 0; memAddr = 32'h0;
        fillLane = -1; fillTag = 28'h0; latency = -1;
        core_req  = 1'b1;
        core_addr = addr;
        @(negedge clk);
        checkOutput("ready_at_accept", longint'(core_ready_o), 1);
        @(posedge clk); #1;
        core_req = 1'b0;
        cyc      = 1;
        reqCount = 0;
        while (cyc < 40) begin
            @(negedge clk);
            if (mem_rd_req_o) begin
                reqCount++;
                memSeen = 1;
                memAddr = mem_addr_o;
            end
            mem_ack = mem_rd_req_o && (reqCount == ackN);
            if (tag_fill_o) begin
                fillLane = int'(tag_index_o);
                fillTag  = tag_tag_o;
            end
            if (core_valid_o) begin
                hit     = core_hit_o;
                lane    = int'(core_lane_o);
                latency = cyc;
                break;
            end
            @(posedge clk); #1;
            cyc++;
        end
        mem_ack = 1'b0;
        @(posedge clk); #1;
    endtask

    typedef struct {
        logic [31:0] addr;
        int          ackN;
        bit          expHit;
        int          expLane;
        bit          expMem;
        logic [31:0] expMemAddr;
        int          expFillLane;
        logic [27:0] expFillTag;
        int          expLatency;
    } vec_t;

    vec_t vecs [13];

    initial begin
        bit          hit;
        int          lane;
        bit          memSeen;
        logic [31:0] memAddr;
        int          fillLane;
        logic [27:0] fillTag;
        int          latency;
        int          cyc;
        int          reqCount;
        int          respCycle;
        int          ackCycle;
        bit          invEarly;
        bit          fillSeen;
        bit          validSeen;

        vecs[0]  = '{32'h0000_1230, 3, 1'b0, 0, 1'b1, 32'h0000_1230, 0,  28'h000_0123, 7};
        vecs[1]  = '{32'h0000_123C, 1, 1'b1, 0, 1'b0, 32'h0000_0000, -1, 28'h000_0000, 2};
        vecs[2]  = '{32'h0000_2004, 1, 1'b0, 1, 1'b1, 32'h0000_2000, 1,  28'h000_0200, 5};
        vecs[3]  = '{32'h0000_3008, 2, 1'b0, 2, 1'b1, 32'h0000_3000, 2,  28'h000_0300, 6};
        vecs[4]  = '{32'h0000_400C, 1, 1'b0, 3, 1'b1, 32'h0000_4000, 3,  28'h000_0400, 5};
        vecs[5]  = '{32'h0000_5000, 1, 1'b0, 4, 1'b1, 32'h0000_5000, 4,  28'h000_0500, 5};
        vecs[6]  = '{32'h0000_6010, 1, 1'b0, 5, 1'b1, 32'h0000_6010, 5,  28'h000_0601, 5};
        vecs[7]  = '{32'h0000_7000, 1, 1'b0, 6, 1'b1, 32'h0000_7000, 6,  28'h000_0700, 5};
        vecs[8]  = '{32'hFFFF_FFF7, 2, 1'b0, 7, 1'b1, 32'hFFFF_FFF0, 7,  28'hFFF_FFFF, 6};
        vecs[9]  = '{32'h0000_9000, 1, 1'b0, 0, 1'b1, 32'h0000_9000, 0,  28'h000_0900, 5};
        vecs[10] = '{32'h0000_5008, 1, 1'b1, 4, 1'b0, 32'h0000_0000, -1, 28'h000_0000, 2};
        vecs[11] = '{32'h0000_9004, 1, 1'b1, 0, 1'b0, 32'h0000_0000, -1, 28'h000_0000, 2};
        vecs[12] = '{32'h0000_123C, 1, 1'b0, 1, 1'b1, 32'h0000_1230, 1,  28'h000_0123, 5};

        rst = 1'b1; core_req = 1'b0; core_addr = 32'h0; inv_req = 1'b0; mem_ack = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checkOutput("reset_core_ready", longint'(core_ready_o), 1);
        checkOutput("reset_busy", longint'(busy_o), 0);
        checkOutput("reset_core_valid", longint'(core_valid_o), 0);
        checkOutput("reset_mem_rd_req", longint'(mem_rd_req_o), 0);
        checkOutput("reset_mem_addr", longint'(mem_addr_o), 0);
        checkOutput("reset_tag_req", longint'(tag_req_o), 0);
        checkOutput("reset_tag_fill", longint'(tag_fill_o), 0);
        checkOutput("reset_tag_invalidate", longint'(tag_invalidate_o), 0);
        checkOutput("reset_inv_ack", longint'(inv_ack_o), 0);
        @(posedge clk); #1;

        for (int v = 0; v < 13; v++) begin
            applyStimulus(vecs[v].addr, vecs[v].ackN, hit, lane, memSeen, memAddr,
                          fillLane, fillTag, latency);
            $display("[TB] vector %0d addr %08h", v, vecs[v].addr);
            checkOutput("vec_hit", longint'(hit), longint'(vecs[v].expHit));
            checkOutput("vec_lane", longint'(lane), longint'(vecs[v].expLane));
            checkOutput("vec_mem_req", longint'(memSeen), longint'(vecs[v].expMem));
            checkOutput("vec_mem_addr", longint'(memAddr), longint'(vecs[v].expMemAddr));
            checkOutput("vec_fill_lane", longint'(fillLane), longint'(vecs[v].expFillLane));
            checkOutput("vec_fill_tag", longint'(fillTag), longint'(vecs[v].expFillTag));
            checkOutput("vec_latency", longint'(latency), longint'(vecs[v].expLatency));
        end

        // Invalidate and core request in the same IDLE cycle: invalidate wins.
        inv_req = 1'b1; core_req = 1'b1; core_addr = 32'h0000_A000;
        @(negedge clk);
        checkOutput("inv_prio_ready", longint'(core_ready_o), 0);
        @(posedge clk); #1;
        @(negedge clk);
        checkOutput("inv_prio_ack", longint'(inv_ack_o), 1);
        checkOutput("inv_prio_invalidate", longint'(tag_invalidate_o), 1);
        checkOutput("inv_prio_no_lookup", longint'(tag_req_o), 0);
        inv_req = 1'b0;
        @(posedge clk); #1;
        applyStimulus(32'h0000_A000, 1, hit, lane, memSeen, memAddr, fillLane, fillTag, latency);
        checkOutput("after_inv_hit", longint'(hit), 0);
        checkOutput("after_inv_fill_lane", longint'(fillLane), 0);
        checkOutput("after_inv_latency", longint'(latency), 5);

        // Invalidate raised during MISS_REQ waits until after the response.
        core_req = 1'b1; core_addr = 32'h0000_B000;
        @(posedge clk); #1;
        core_req = 1'b0;
        cyc = 1; reqCount = 0; respCycle = -1; ackCycle = -1; invEarly = 0; lane = -1; hit = 1;
        while (cyc < 40) begin
            @(negedge clk);
            if (mem_rd_req_o) begin
                reqCount++;
                inv_req = 1'b1;
            end
            mem_ack = mem_rd_req_o && (reqCount == 3);
            if (core_valid_o) begin
                respCycle = cyc;
                hit       = core_hit_o;
                lane      = int'(core_lane_o);
            end
            if (inv_ack_o) begin
                ackCycle = cyc;
                if (respCycle < 0) invEarly = 1;
                inv_req = 1'b0;
                mem_ack = 1'b0;
                break;
            end
            @(posedge clk); #1;
            cyc++;
        end
        inv_req = 1'b0;
        mem_ack = 1'b0;
        @(posedge clk); #1;
        checkOutput("inv_wait_resp_cycle", longint'(respCycle), 7);
        checkOutput("inv_wait_ack_cycle", longint'(ackCycle), 9);
        checkOutput("inv_wait_not_early", longint'(invEarly), 0);
        checkOutput("inv_wait_hit", longint'(hit), 0);
        checkOutput("inv_wait_lane", longint'(lane), 1);

        // Reset while in MISS_REQ abandons the miss; a stray ack is ignored.
        core_req = 1'b1; core_addr = 32'h0000_C000;
        @(posedge clk); #1;
        core_req = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        checkOutput("pre_reset_mem_req", longint'(mem_rd_req_o), 1);
        rst = 1'b1;
        #1;
        checkOutput("reset_miss_mem_req", longint'(mem_rd_req_o), 0);
        checkOutput("reset_miss_busy", longint'(busy_o), 0);
        checkOutput("reset_miss_ready", longint'(core_ready_o), 1);
        checkOutput("reset_miss_mem_addr", longint'(mem_addr_o), 0);
        @(negedge clk);
        rst = 1'b0;
        mem_ack = 1'b1;
        @(negedge clk);
        mem_ack = 1'b0;
        fillSeen = 0; validSeen = 0; memSeen = 0;
        repeat (6) begin
            @(negedge clk);
            fillSeen  |= tag_fill_o;
            validSeen |= core_valid_o;
            memSeen   |= mem_rd_req_o;
        end
        checkOutput("stray_ack_fill", longint'(fillSeen), 0);
        checkOutput("stray_ack_valid", longint'(validSeen), 0);
        checkOutput("stray_ack_mem_req", longint'(memSeen), 0);
        checkOutput("stray_ack_busy", longint'(busy_o), 0);
        @(posedge clk); #1;
        applyStimulus(32'h0000_D000, 2, hit, lane, memSeen, memAddr, fillLane, fillTag, latency);
        checkOutput("post_reset_fill_lane", longint'(fillLane), 0);
        checkOutput("post_reset_mem_addr", longint'(memAddr), 32'h0000_D000);
        checkOutput("post_reset_latency", longint'(latency), 6);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
